bram_fifo_ctrl: RTL and testbench

- Sequencer that runs one BlockRAM_1KB primitive as a 512 x 16 first-word-fall-through FIFO.
- Provides valid/ready push and pop interfaces to fabric logic.
- Drives the RAM's 8-bit addresses plus the control fields packed into wr_data (write enable, address MSB, read-lane select).
- Outputs the constant C0..C5 configuration: 16-bit write mode, 16-bit read mode, dynamic write enable, no output register.

---
 rtl/bram_fifo_ctrl_if.sv | 31 +++
 rtl/bram_fifo_ctrl.sv | 102 ++++++++++
 tb/tb_bram_fifo_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/bram_fifo_ctrl_if.sv
// Push/pop handshakes, status and BlockRAM port bundle for bram_fifo_ctrl.
// slave is the controller side; master is the fabric/RAM side.
interface bram_fifo_ctrl_if;
  logic        flush;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic [9:0]  level;
  logic        almost_full;
  logic        almost_empty;
  logic [7:0]  ram_wr_addr;
  logic [31:0] ram_wr_data;
  logic [7:0]  ram_rd_addr;
  logic [31:0] ram_rd_data;
  logic [5:0]  ram_cfg;

  modport slave (
    input  flush, in_valid, in_data, out_ready, ram_rd_data,
    output in_ready, out_valid, out_data, level, almost_full, almost_empty,
    output ram_wr_addr, ram_wr_data, ram_rd_addr, ram_cfg
  );

  modport master (
    output flush, in_valid, in_data, out_ready, ram_rd_data,
    input  in_ready, out_valid, out_data, level, almost_full, almost_empty,
    input  ram_wr_addr, ram_wr_data, ram_rd_addr, ram_cfg
  );
endinterface

// File: rtl/bram_fifo_ctrl.sv
// 512x16 FWFT FIFO sequencer around one BlockRAM_1KB; push-to-out_valid latency 2 cycles from empty.
// Backpressure: in_ready drops at level 512; reads stop issuing once buffered + inflight words reach 2.
module bram_fifo_ctrl #(
  parameter int WR_EN_BIT  = 20,
  parameter int WR_MSB_LSB = 16,
  parameter int RD_MSB_LSB = 24,
  parameter int AF_THRESH  = 448,
  parameter int AE_THRESH  = 64
) (
  input logic             clk,
  input logic             resetn,
  bram_fifo_ctrl_if.slave fifo
);
  localparam logic [9:0] AF_L   = 10'(AF_THRESH);
  localparam logic [9:0] AE_L   = 10'(AE_THRESH);
  localparam logic [9:0] FULL_L = 10'd512;

  logic [9:0]  r_wptr;
  logic [9:0]  r_rptr;
  logic [9:0]  r_level;
  logic        r_inflight;
  logic        r_run;
  logic [1:0]  r_cnt;
  logic        r_head;
  logic [15:0] r_buf [2];

  logic        w_push;
  logic        w_pop;
  logic        w_issue;
  logic        w_store;
  logic [2:0]  w_occ;
  logic [31:0] w_wr_data;
  logic        w_unused_rd;

  assign w_unused_rd = ^fifo.ram_rd_data[31:16];

  assign fifo.in_ready  = r_run && (r_level < FULL_L) && !fifo.flush;
  assign w_push         = fifo.in_valid && fifo.in_ready;

  // A word returning from the RAM is presented straight from rd_data until it lands in the buffer.
  assign fifo.out_valid = (r_cnt != 2'd0) || r_inflight;
  assign fifo.out_data  = ((r_cnt == 2'd0) && r_inflight) ? fifo.ram_rd_data[15:0]
                                                           : r_buf[r_head];
  assign w_pop          = fifo.out_valid && fifo.out_ready && !fifo.flush;

  assign w_occ   = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = (r_wptr != r_rptr) && (w_occ < 3'd2) && !fifo.flush;
  assign w_store = r_inflight && !((r_cnt == 2'd0) && w_pop);

  assign fifo.level        = r_level;
  assign fifo.almost_full  = (r_level >= AF_L);
  assign fifo.almost_empty = (r_level <= AE_L);
  assign fifo.ram_wr_addr  = r_wptr[7:0];
  assign fifo.ram_rd_addr  = r_rptr[7:0];
  assign fifo.ram_wr_data  = w_wr_data;
  assign fifo.ram_cfg      = 6'b010100;

  always_comb begin
    w_wr_data = '0;
    if (w_push) begin
      w_wr_data[15:0]         = fifo.in_data;
      w_wr_data[WR_MSB_LSB]   = r_wptr[8];
      w_wr_data[WR_EN_BIT]    = 1'b1;
    end
    if (w_issue) begin
      w_wr_data[RD_MSB_LSB]   = r_rptr[8];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_inflight <= 1'b0;
      r_run      <= 1'b0;
      r_cnt      <= '0;
      r_head     <= 1'b0;
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
    end else begin
      r_run <= 1'b1;
      if (fifo.flush) begin
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_level    <= '0;
        r_inflight <= 1'b0;
        r_cnt      <= '0;
        r_head     <= 1'b0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 10'd1;
        if (w_issue) r_rptr <= r_rptr + 10'd1;
        r_inflight <= w_issue;
        if (w_push && !w_pop) r_level <= r_level + 10'd1;
        else if (!w_push && w_pop) r_level <= r_level - 10'd1;
        if (w_store) r_buf[r_head ^ r_cnt[0]] <= fifo.ram_rd_data[15:0];
        r_cnt <= w_occ[1:0];
        if (w_pop && (r_cnt != 2'd0)) r_head <= ~r_head;
      end
    end
  end
endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Directed bench for bram_fifo_ctrl with a behavioural BlockRAM and a queue scoreboard.
module tb_bram_fifo_ctrl;
  logic clk = 1'b0;
  logic resetn = 1'b0;

  bram_fifo_ctrl_if bus ();

  bram_fifo_ctrl dut (
    .clk    (clk),
    .resetn (resetn),
    .fifo   (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [512];

  always @(posedge clk) begin
    if (bus.ram_wr_data[20]) mem[{bus.ram_wr_data[16], bus.ram_wr_addr}] <= bus.ram_wr_data[15:0];
    bus.ram_rd_data <= {16'hDEAD, mem[{bus.ram_wr_data[24], bus.ram_rd_addr}]};
  end

  int          n_chk = 0;
  int          n_err = 0;
  int          n_pop = 0;
  int          m_level = 0;
  logic [9:0]  m_wcnt = '0;
  logic [15:0] q [$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic iv, input logic [15:0] id, input logic ordy, input logic fl);
    logic exp_rdy;
    logic push;
    logic pop;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    bus.flush     = fl;
    #1;
    exp_rdy = (m_level < 512) && !fl;
    chk("in_ready", {31'b0, bus.in_ready}, {31'b0, exp_rdy});
    chk("level", {22'b0, bus.level}, m_level);
    chk("almost_full", {31'b0, bus.almost_full}, {31'b0, (m_level >= 448)});
    chk("almost_empty", {31'b0, bus.almost_empty}, {31'b0, (m_level <= 64)});
    pop = bus.out_valid && ordy && !fl;
    if (pop) begin
      chk("pop_has_word", {31'b0, (q.size() != 0)}, 32'd1);
      if (q.size() != 0) begin
        chk("out_data", {16'b0, bus.out_data}, {16'b0, q[0]});
        void'(q.pop_front());
      end
      n_pop++;
    end
    push = iv && exp_rdy;
    chk("wr_en", {31'b0, bus.ram_wr_data[20]}, {31'b0, push});
    if (push) begin
      chk("wr_addr", {23'b0, bus.ram_wr_data[16], bus.ram_wr_addr}, {23'b0, m_wcnt[8:0]});
      q.push_back(id);
      m_wcnt++;
    end
    if (fl) begin
      q.delete();
      m_level = 0;
      m_wcnt  = '0;
    end else begin
      m_level = m_level + (push ? 1 : 0) - (pop ? 1 : 0);
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 1100 && q.size() != 0; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0);
    chk(tag, q.size(), 32'd0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;

    // reset state
    #2;
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_out_data", {16'b0, bus.out_data}, 32'd0);
    chk("rst_level", {22'b0, bus.level}, 32'd0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("rst_ae", {31'b0, bus.almost_empty}, 32'd1);
    chk("rst_af", {31'b0, bus.almost_full}, 32'd0);
    chk("rst_wr_data", bus.ram_wr_data, 32'd0);
    chk("rst_addrs", {16'b0, bus.ram_wr_addr, bus.ram_rd_addr}, 32'd0);
    chk("cfg", {26'b0, bus.ram_cfg}, 32'h14);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("rdy_before_edge", {31'b0, bus.in_ready}, 32'd0);

    // single word latency
    cyc(1'b1, 16'hA5C3, 1'b0, 1'b0);
    chk("sw_wr_addr", {24'b0, bus.ram_wr_addr}, 32'd0);
    chk("sw_wr_lane", {31'b0, bus.ram_wr_data[16]}, 32'd0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    chk("sw_rd_addr", {24'b0, bus.ram_rd_addr}, 32'd0);
    chk("sw_rd_lane", {31'b0, bus.ram_wr_data[24]}, 32'd0);
    chk("sw_ov_c1", {31'b0, bus.out_valid}, 32'd0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    chk("sw_ov_c2", {31'b0, bus.out_valid}, 32'd1);
    chk("sw_od_c2", {16'b0, bus.out_data}, 32'h0000A5C3);
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    chk("sw_empty", {31'b0, bus.out_valid}, 32'd0);

    // fill to full, then push+pop at full must not accept the push
    for (int i = 0; i < 512; i++) cyc(1'b1, 16'(i * 7 + 3), 1'b0, 1'b0);
    cyc(1'b1, 16'hFFFF, 1'b1, 1'b0);
    chk("full_level", {22'b0, bus.level}, 32'd512);
    chk("full_in_ready", {31'b0, bus.in_ready}, 32'd0);
    drain("fill_drain");

    // streaming: one word per cycle after the 2-cycle fill
    p0 = n_pop;
    for (int i = 0; i < 2000; i++) cyc(1'b1, 16'(i ^ 16'h3C3C), 1'b1, 1'b0);
    chk("stream_pops", n_pop - p0, 32'd1998);
    drain("stream_drain");

    // random backpressure
    for (int i = 0; i < 1500; i++)
      cyc(($urandom_range(1, 0) == 1), 16'($urandom), ($urandom_range(99, 0) < 30), 1'b0);
    drain("bp_drain");

    // flush with a read in flight at level 10
    for (int i = 0; i < 12; i++) cyc(1'b1, 16'(100 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 1'b1);
    cyc(1'b1, 16'h0001, 1'b0, 1'b0);
    chk("fl_ov", {31'b0, bus.out_valid}, 32'd0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    chk("fl_first_ov", {31'b0, bus.out_valid}, 32'd1);
    chk("fl_first_data", {16'b0, bus.out_data}, 32'h1);
    drain("fl_drain");

    // asynchronous reset mid-stream at level 37
    for (int i = 0; i < 37; i++) cyc(1'b1, 16'(i + 500), 1'b0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    #2;
    resetn = 1'b0;
    #1;
    chk("mr_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("mr_level", {22'b0, bus.level}, 32'd0);
    chk("mr_wr_en", {31'b0, bus.ram_wr_data[20]}, 32'd0);
    q.delete();
    m_level = 0;
    m_wcnt = '0;
    @(negedge clk);
    resetn = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("mr_rdy_before_edge", {31'b0, bus.in_ready}, 32'd0);
    cyc(1'b1, 16'hBEEF, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    chk("mr_first_data", {16'b0, bus.out_data}, 32'hBEEF);
    drain("mr_drain");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
